// File: rtl/mem_responder.sv
// Word-addressed single-port RAM responder behind a req/ready handshake.
// Latency: ready pulses LATENCY+1 cycles after the accepting edge; one access per LATENCY+2 cycles.
// Backpressure: none queued; req is only taken in IDLE or on the RESP exit edge, ignored otherwise.
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH];

  logic          fault;
  logic [AW-1:0] idx;
  logic          mem_we;

  // Decode the latched address: misaligned or beyond the array is a fault.
  always_comb begin
    fault  = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);
    idx    = addr_q[AW+1:2];
    mem_we = (state_q == WAIT) && (cnt_q == 4'd0) && we_q && !fault;
  end

  // Next-state logic. The RESP exit edge doubles as an acceptance edge so
  // that a held req sustains one access every LATENCY+2 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = 32'd0;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(LATENCY);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = fault;
          rdata_d = (fault || we_q) ? 32'd0 : mem_q[idx];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule
